// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter granting one owner until done, req drop or (ARB_TIMEOUT_EN) hold limit.
// Latency: grant registered one cycle after req is sampled in IDLE; at least one IDLE cycle between grants.
// Backpressure: owner holds the resource until it releases; other requesters wait, nothing is queued.
module rr_arbiter_16 #(
    parameter int MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        grant_valid,
    output logic        timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  last;
    logic [3:0]  cand;
    logic [3:0]  pick_idx;
    logic        pick_vld;
    logic        owner_req;
    logic        release_now;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter_16: MAX_HOLD must be in 2..255");
    end

    // Scan downward from last-1; iterating far-to-near lets the nearest candidate win.
    always_comb begin
        cand     = 4'd0;
        pick_idx = 4'd0;
        pick_vld = 1'b0;
        for (int k = 16; k >= 1; k--) begin
            cand = last - 4'(k);
            if (req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_req = req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       hold_limit;

    assign hold_limit  = (hold_cnt == 8'(MAX_HOLD - 1));
    assign release_now = done | ~owner_req | hold_limit;
`else
    assign release_now = done | ~owner_req;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 16'd0;
            grant_idx   <= 4'd0;
            grant_valid <= 1'b0;
            last        <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= 8'd0;
            timeout     <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state       <= BUSY;
                        grant       <= 16'd1 << pick_idx;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt    <= 8'd0;
`endif
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= 16'd0;
                        grant_idx   <= 4'd0;
                        grant_valid <= 1'b0;
                        last        <= grant_idx;
`ifdef ARB_TIMEOUT_EN
                        // A voluntary release on the limit cycle wins over the forced one.
                        timeout     <= ~done & owner_req;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16; expected values are hand-derived per scenario.
module tb_rr_arbiter_16;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int checks;
    int failures;

    rr_arbiter_16 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 16'd0;
        done  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 16'hFFFF;
        done  = 1'b0;
        tick();
        checks++;
        if (grant !== 16'd0) begin
            failures++; $display("FAIL reset_grant got=%h exp=%h", grant, 16'd0);
        end
        checks++;
        if (grant_idx !== 4'd0) begin
            failures++; $display("FAIL reset_idx got=%0d exp=0", grant_idx);
        end
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", grant_valid);
        end
        checks++;
        if (timeout !== 1'b0) begin
            failures++; $display("FAIL reset_timeout got=%b exp=0", timeout);
        end
        reset = 1'b0;
        req   = 16'd0;
    endtask

    task automatic test_first_grant();
        apply_reset();
        req = 16'h8001;
        tick();
        checks++;
        if (grant !== 16'h8000 || grant_idx !== 4'd15 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_grant got=%h/%0d/%b exp=8000/15/1", grant, grant_idx, grant_valid);
        end
        done = 1'b1;
        req  = 16'd0;
        tick();
        checks++;
        if (grant !== 16'd0 || grant_valid !== 1'b0) begin
            failures++; $display("FAIL first_release got=%h/%b exp=0000/0", grant, grant_valid);
        end
        done = 1'b0;
    endtask

    task automatic test_rotation();
        logic [3:0]  e;
        logic [15:0] eg;
        apply_reset();
        req = 16'hFFFF;
        for (int i = 0; i <= 16; i++) begin
            e  = 4'(15 - i);
            eg = 16'd1 << e;
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== e || grant !== eg) begin
                failures++;
                $display("FAIL rotation_grant[%0d] got=%h/%0d/%b exp=%h/%0d/1",
                         i, grant, grant_idx, grant_valid, eg, e);
            end
            done = 1'b1;
            tick();
            checks++;
            if (grant_valid !== 1'b0 || grant !== 16'd0) begin
                failures++; $display("FAIL rotation_idle[%0d] got=%h/%b exp=0000/0", i, grant, grant_valid);
            end
            done = 1'b0;
        end
        req = 16'd0;
        tick();
    endtask

    task automatic test_req_drop();
        apply_reset();
        req = 16'h0008;
        tick();
        checks++;
        if (grant_idx !== 4'd3 || grant !== 16'h0008 || grant_valid !== 1'b1) begin
            failures++; $display("FAIL drop_owner got=%h/%0d exp=0008/3", grant, grant_idx);
        end
        req = 16'hF00C;
        tick();
        tick();
        checks++;
        if (grant_idx !== 4'd3 || grant !== 16'h0008 || grant_valid !== 1'b1) begin
            failures++; $display("FAIL busy_hold got=%h/%0d exp=0008/3", grant, grant_idx);
        end
        req = 16'h0200;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || grant !== 16'd0) begin
            failures++; $display("FAIL drop_release got=%h/%b exp=0000/0", grant, grant_valid);
        end
        tick();
        checks++;
        if (grant_idx !== 4'd9 || grant !== 16'h0200 || grant_valid !== 1'b1) begin
            failures++; $display("FAIL drop_regrant got=%h/%0d exp=0200/9", grant, grant_idx);
        end
        req = 16'd0;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 16'h0080;
        tick();
        checks++;
        if (grant_idx !== 4'd7 || grant_valid !== 1'b1) begin
            failures++; $display("FAIL areset_owner got=%0d/%b exp=7/1", grant_idx, grant_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 16'd0 || grant_valid !== 1'b0 || grant_idx !== 4'd0) begin
            failures++;
            $display("FAIL areset_drop got=%h/%0d/%b exp=0000/0/0", grant, grant_idx, grant_valid);
        end
        req = 16'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_done_idle();
        apply_reset();
        done = 1'b1;
        tick();
        tick();
        checks++;
        if (grant !== 16'd0 || grant_idx !== 4'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_idle got=%h/%0d/%b/%b exp=0000/0/0/0", grant, grant_idx, grant_valid, timeout);
        end
        done = 1'b0;
    endtask

    task automatic test_hold_limit();
        apply_reset();
        req = 16'h0004;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 4'd2 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL hold_busy[%0d] got=%b/%0d/%b exp=1/2/0", c, grant_valid, grant_idx, timeout);
            end
        end
        tick();
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            failures++; $display("FAIL hold_timeout got=%b/%b exp=0/1", grant_valid, timeout);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd2 || timeout !== 1'b0) begin
            failures++; $display("FAIL hold_regrant got=%b/%0d/%b exp=1/2/0", grant_valid, grant_idx, timeout);
        end
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++; $display("FAIL hold_done_wins got=%b/%b exp=0/0", grant_valid, timeout);
        end
        done = 1'b0;
`else
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 4'd2 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL hold_nolimit[%0d] got=%b/%0d/%b exp=1/2/0", c, grant_valid, grant_idx, timeout);
            end
        end
`endif
        req = 16'd0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = 16'd0;
        done     = 1'b0;
        test_reset();
        test_first_grant();
        test_rotation();
        test_req_drop();
        test_async_reset();
        test_done_idle();
        test_hold_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
